// File: rtl/seq_div_if.sv
// Handshake and data bundle for the sequential divider.
interface seq_div_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, dividend, divisor,
    input  busy, done, result
  );

  modport slave (
    input  start, op, dividend, divisor,
    output busy, done, result
  );
endinterface

// File: rtl/seq_div.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
module seq_div #(
  parameter int unsigned XLEN = 32
) (
  input logic     clk,
  input logic     rst_n,
  seq_div_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [5:0] LAST = 6'(XLEN - 1);

  logic [1:0]      state;
  logic [5:0]      cnt;
  logic [XLEN-1:0] q;
  logic [XLEN-1:0] d;
  logic [XLEN-1:0] r;
  logic [XLEN-1:0] result;
  logic            is_rem;
  logic            negq;
  logic            negr;

  logic            sgn;
  logic            a_neg;
  logic            b_neg;
  logic            div0;
  logic            ovf;
  logic [XLEN-1:0] min_val;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  always_comb begin
    min_val          = '0;
    min_val[XLEN-1]  = 1'b1;
    sgn   = ~bus.op[0];
    a_neg = sgn & bus.dividend[XLEN-1];
    b_neg = sgn & bus.divisor[XLEN-1];
    a_mag = a_neg ? -bus.dividend : bus.dividend;
    b_mag = b_neg ? -bus.divisor  : bus.divisor;
    div0  = (bus.divisor == '0);
    ovf   = sgn && (bus.dividend == min_val) && (bus.divisor == '1);
  end

  // Partial remainder shifted left with the next dividend bit; a clear top bit
  // of the difference means the divisor fits and the quotient bit is 1.
  logic [XLEN:0]   rs;
  logic [XLEN:0]   diff;
  logic            fits;
  logic [XLEN-1:0] r_nx;
  logic [XLEN-1:0] q_nx;
  logic [XLEN-1:0] quot_f;
  logic [XLEN-1:0] rem_f;

  always_comb begin
    rs     = {r, q[XLEN-1]};
    diff   = rs - {1'b0, d};
    fits   = ~diff[XLEN];
    r_nx   = fits ? diff[XLEN-1:0] : rs[XLEN-1:0];
    q_nx   = {q[XLEN-2:0], fits};
    quot_f = negq ? -q_nx : q_nx;
    rem_f  = negr ? -r_nx : r_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      q      <= '0;
      d      <= '0;
      r      <= '0;
      result <= '0;
      is_rem <= 1'b0;
      negq   <= 1'b0;
      negr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            is_rem <= bus.op[1];
            negq   <= a_neg ^ b_neg;
            negr   <= a_neg;
            q      <= a_mag;
            d      <= b_mag;
            r      <= '0;
            cnt    <= '0;
            if (div0) begin
              result <= bus.op[1] ? bus.dividend : '1;
              state  <= DONE;
            end else if (ovf) begin
              result <= bus.op[1] ? '0 : bus.dividend;
              state  <= DONE;
            end else begin
              state  <= CALC;
            end
          end
        end
        CALC: begin
          q   <= q_nx;
          r   <= r_nx;
          cnt <= cnt + 6'd1;
          if (cnt == LAST) begin
            result <= is_rem ? rem_f : quot_f;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = result;

endmodule
